// File: rtl/arm_pkg.sv
// Shared decode constants, condition codes and ID/EX control bundle for the ARM pipeline.
package arm_pkg;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] cmd;
    } id_ex_ctrl_t;

endpackage

// File: rtl/register_file.sv
// 16x32 register file with two combinational read ports and one write port.
// Optional same-cycle write-through bypass enabled by macro ID_WB_BYPASS_EN.
module register_file #(
    parameter int REG_CNT = 16,
    parameter int AW      = $clog2(REG_CNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic [31:0]   rd_data1,
    output logic [31:0]   rd_data2,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    logic [31:0] regs [REG_CNT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef ID_WB_BYPASS_EN
    // Write-through lets a same-cycle WB result reach the ID/EX operands.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        if (wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
        if (wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
    end
`else
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
    end
`endif

endmodule

// File: rtl/id_stage.sv
// ARM instruction-decode stage: register file, control decoder, condition check, ID/EX register.
// Optional macro ID_WB_BYPASS_EN enables write-through bypass in the register file.
module id_stage
    import arm_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int REG_CNT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            wb_en,
    input  logic [3:0]      wb_dest,
    input  logic [31:0]     wb_value,
    input  logic [3:0]      status_in,
    input  logic            hazard_stall,
    input  logic            flush,
    output logic [3:0]      src1,
    output logic [3:0]      src2,
    output logic            two_src,
    output logic            ex_wb_en,
    output logic            ex_mem_r_en,
    output logic            ex_mem_w_en,
    output logic            ex_b,
    output logic            ex_s,
    output logic [3:0]      ex_cmd,
    output logic [PC_W-1:0] ex_pc,
    output logic [31:0]     ex_val_rn,
    output logic [31:0]     ex_val_rm,
    output logic            ex_imm,
    output logic [11:0]     ex_shift_operand,
    output logic [23:0]     ex_signed_imm_24,
    output logic [3:0]      ex_dest,
    output logic [3:0]      ex_src1,
    output logic [3:0]      ex_src2
);

    logic [1:0]  mode;
    logic [3:0]  opcode;
    logic        s_bit;
    logic        imm;
    cond_t       cond;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        cond_ok;
    logic        dp_valid;
    id_ex_ctrl_t dec_ctrl;
    id_ex_ctrl_t ctrl;
    id_ex_ctrl_t ex_ctrl;
    logic [31:0] val_rn;
    logic [31:0] val_rm;

    assign mode   = instr_in[27:26];
    assign opcode = instr_in[24:21];
    assign s_bit  = instr_in[20];
    assign imm    = instr_in[25];
    assign cond   = cond_t'(instr_in[31:28]);

    assign {flag_n, flag_z, flag_c, flag_v} = status_in;

    always_comb begin
        dec_ctrl = '0;
        dp_valid = 1'b1;
        case (mode)
            MODE_DP: begin
                case (opcode)
                    OP_MOV:  begin dec_ctrl.cmd = CMD_MOV; dec_ctrl.wb_en = 1'b1; end
                    OP_MVN:  begin dec_ctrl.cmd = CMD_MVN; dec_ctrl.wb_en = 1'b1; end
                    OP_ADD:  begin dec_ctrl.cmd = CMD_ADD; dec_ctrl.wb_en = 1'b1; end
                    OP_ADC:  begin dec_ctrl.cmd = CMD_ADC; dec_ctrl.wb_en = 1'b1; end
                    OP_SUB:  begin dec_ctrl.cmd = CMD_SUB; dec_ctrl.wb_en = 1'b1; end
                    OP_SBC:  begin dec_ctrl.cmd = CMD_SBC; dec_ctrl.wb_en = 1'b1; end
                    OP_AND:  begin dec_ctrl.cmd = CMD_AND; dec_ctrl.wb_en = 1'b1; end
                    OP_ORR:  begin dec_ctrl.cmd = CMD_ORR; dec_ctrl.wb_en = 1'b1; end
                    OP_EOR:  begin dec_ctrl.cmd = CMD_EOR; dec_ctrl.wb_en = 1'b1; end
                    OP_CMP:  dec_ctrl.cmd = CMD_SUB;
                    OP_TST:  dec_ctrl.cmd = CMD_AND;
                    default: dp_valid = 1'b0;
                endcase
                dec_ctrl.s = s_bit & dp_valid;
            end
            MODE_MEM: begin
                dec_ctrl.cmd = CMD_ADD;
                if (s_bit) begin
                    dec_ctrl.mem_r_en = 1'b1;
                    dec_ctrl.wb_en    = 1'b1;
                end else begin
                    dec_ctrl.mem_w_en = 1'b1;
                end
            end
            MODE_BR: begin
                dec_ctrl.b   = 1'b1;
                dec_ctrl.cmd = CMD_NOP;
            end
            default: dec_ctrl = '0;
        endcase
    end

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            COND_EQ: cond_ok = flag_z;
            COND_NE: cond_ok = !flag_z;
            COND_CS: cond_ok = flag_c;
            COND_CC: cond_ok = !flag_c;
            COND_MI: cond_ok = flag_n;
            COND_PL: cond_ok = !flag_n;
            COND_VS: cond_ok = flag_v;
            COND_VC: cond_ok = !flag_v;
            COND_HI: cond_ok = flag_c && !flag_z;
            COND_LS: cond_ok = !flag_c || flag_z;
            COND_GE: cond_ok = (flag_n == flag_v);
            COND_LT: cond_ok = (flag_n != flag_v);
            COND_GT: cond_ok = !flag_z && (flag_n == flag_v);
            COND_LE: cond_ok = flag_z || (flag_n != flag_v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // A failed condition squashes every control bit, turning the instruction into a NOP.
    assign ctrl    = cond_ok ? dec_ctrl : '0;
    assign src1    = instr_in[19:16];
    assign src2    = ctrl.mem_w_en ? instr_in[15:12] : instr_in[3:0];
    assign two_src = !imm || ctrl.mem_w_en;

    register_file #(
        .REG_CNT (REG_CNT)
    ) u_register_file (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (src1),
        .rd_addr2 (src2),
        .rd_data1 (val_rn),
        .rd_data2 (val_rm),
        .wr_en    (wb_en),
        .wr_addr  (wb_dest),
        .wr_data  (wb_value)
    );

    // Stall inserts a bubble by zeroing control only; flush kills the whole slot.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            ex_ctrl          <= '0;
            ex_pc            <= '0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_imm           <= 1'b0;
            ex_shift_operand <= '0;
            ex_signed_imm_24 <= '0;
            ex_dest          <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
        end else begin
            ex_ctrl          <= hazard_stall ? '0 : ctrl;
            ex_pc            <= pc_in;
            ex_val_rn        <= val_rn;
            ex_val_rm        <= val_rm;
            ex_imm           <= imm;
            ex_shift_operand <= instr_in[11:0];
            ex_signed_imm_24 <= instr_in[23:0];
            ex_dest          <= instr_in[15:12];
            ex_src1          <= src1;
            ex_src2          <= src2;
        end
    end

    assign ex_wb_en    = ex_ctrl.wb_en;
    assign ex_mem_r_en = ex_ctrl.mem_r_en;
    assign ex_mem_w_en = ex_ctrl.mem_w_en;
    assign ex_b        = ex_ctrl.b;
    assign ex_s        = ex_ctrl.s;
    assign ex_cmd      = ex_ctrl.cmd;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage with hand-computed expectations.
// Bypass expectations follow macro ID_WB_BYPASS_EN.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic [9:0]  pc_in;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  status_in;
    logic        hazard_stall;
    logic        flush;
    logic [3:0]  src1, src2;
    logic        two_src;
    logic        ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s;
    logic [3:0]  ex_cmd;
    logic [9:0]  ex_pc;
    logic [31:0] ex_val_rn, ex_val_rm;
    logic        ex_imm;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_signed_imm_24;
    logic [3:0]  ex_dest, ex_src1, ex_src2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    id_stage #(.PC_W(10), .REG_CNT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .instr_in         (instr_in),
        .pc_in            (pc_in),
        .wb_en            (wb_en),
        .wb_dest          (wb_dest),
        .wb_value         (wb_value),
        .status_in        (status_in),
        .hazard_stall     (hazard_stall),
        .flush            (flush),
        .src1             (src1),
        .src2             (src2),
        .two_src          (two_src),
        .ex_wb_en         (ex_wb_en),
        .ex_mem_r_en      (ex_mem_r_en),
        .ex_mem_w_en      (ex_mem_w_en),
        .ex_b             (ex_b),
        .ex_s             (ex_s),
        .ex_cmd           (ex_cmd),
        .ex_pc            (ex_pc),
        .ex_val_rn        (ex_val_rn),
        .ex_val_rm        (ex_val_rm),
        .ex_imm           (ex_imm),
        .ex_shift_operand (ex_shift_operand),
        .ex_signed_imm_24 (ex_signed_imm_24),
        .ex_dest          (ex_dest),
        .ex_src1          (ex_src1),
        .ex_src2          (ex_src2)
    );

    task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic [9:0] pc,
                                 input logic [3:0] st, input logic stall, input logic fl,
                                 input logic we, input logic [3:0] wd, input logic [31:0] wv);
        rst          = r;
        instr_in     = ins;
        pc_in        = pc;
        status_in    = st;
        hazard_stall = stall;
        flush        = fl;
        wb_en        = we;
        wb_dest      = wd;
        wb_value     = wv;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] bypass_exp;
`ifdef ID_WB_BYPASS_EN
        bypass_exp = 32'h55;
`else
        bypass_exp = 32'h11;
`endif
        // Reset held for two cycles
        applyStimulus(1'b0, 32'hE0831003, 10'h004, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        stepCycle();
        checkOutput("rst_wb_en", {31'b0, ex_wb_en}, 32'h0);
        checkOutput("rst_cmd", {28'b0, ex_cmd}, 32'h0);
        checkOutput("rst_pc", {22'b0, ex_pc}, 32'h0);
        checkOutput("rst_dest", {28'b0, ex_dest}, 32'h0);

        // First decode after reset: R3 reads as 0
        applyStimulus(1'b1, 32'hE0831003, 10'h004, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("rst_r3_read", ex_val_rn, 32'h0);
        checkOutput("add0_cmd", {28'b0, ex_cmd}, 32'h2);

        // Write R3=0xAA under a failing EQ NOP
        applyStimulus(1'b1, 32'h00000000, 10'h008, 4'h0, 1'b0, 1'b0, 1'b1, 4'h3, 32'hAA);
        stepCycle();
        checkOutput("nop_eq_wb_en", {31'b0, ex_wb_en}, 32'h0);

        // ADD R1,R3,R3 while writing R2=0x11
        applyStimulus(1'b1, 32'hE0831003, 10'h00C, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2, 32'h11);
        #1;
        checkOutput("add_src1", {28'b0, src1}, 32'h3);
        checkOutput("add_src2", {28'b0, src2}, 32'h3);
        checkOutput("add_two_src", {31'b0, two_src}, 32'h1);
        stepCycle();
        checkOutput("add_val_rn", ex_val_rn, 32'hAA);
        checkOutput("add_val_rm", ex_val_rm, 32'hAA);
        checkOutput("add_cmd", {28'b0, ex_cmd}, 32'h2);
        checkOutput("add_wb_en", {31'b0, ex_wb_en}, 32'h1);
        checkOutput("add_dest", {28'b0, ex_dest}, 32'h1);
        checkOutput("add_pc", {22'b0, ex_pc}, 32'h00C);
        checkOutput("add_src1_reg", {28'b0, ex_src1}, 32'h3);

        // MOVNE with Z=1 fails
        applyStimulus(1'b1, 32'h13A01005, 10'h010, 4'b0100, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("movne_fail_wb_en", {31'b0, ex_wb_en}, 32'h0);
        checkOutput("movne_fail_cmd", {28'b0, ex_cmd}, 32'h0);
        checkOutput("movne_fail_imm", {31'b0, ex_imm}, 32'h1);

        // MOVNE with Z=0 passes; immediate operand means a single source
        applyStimulus(1'b1, 32'h13A01005, 10'h014, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("movne_two_src", {31'b0, two_src}, 32'h0);
        stepCycle();
        checkOutput("movne_cmd", {28'b0, ex_cmd}, 32'h1);
        checkOutput("movne_wb_en", {31'b0, ex_wb_en}, 32'h1);
        checkOutput("movne_shift_op", {20'b0, ex_shift_operand}, 32'h005);

        // MOVHI with C=1,Z=0
        applyStimulus(1'b1, 32'h83A01005, 10'h018, 4'b0010, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("movhi_cmd", {28'b0, ex_cmd}, 32'h1);

        // CMP R3,R4 with S: no write-back, flags update
        applyStimulus(1'b1, 32'hE1530004, 10'h01C, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("cmp_src2", {28'b0, src2}, 32'h4);
        stepCycle();
        checkOutput("cmp_cmd", {28'b0, ex_cmd}, 32'h4);
        checkOutput("cmp_wb_en", {31'b0, ex_wb_en}, 32'h0);
        checkOutput("cmp_s", {31'b0, ex_s}, 32'h1);

        // Unlisted opcode 0111 is a NOP
        applyStimulus(1'b1, 32'hE0E12003, 10'h020, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("nop_op_cmd", {28'b0, ex_cmd}, 32'h0);
        checkOutput("nop_op_wb_en", {31'b0, ex_wb_en}, 32'h0);

        // STR R1,[R0,#4]
        applyStimulus(1'b1, 32'hE5801004, 10'h024, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("str_src2", {28'b0, src2}, 32'h1);
        checkOutput("str_two_src", {31'b0, two_src}, 32'h1);
        stepCycle();
        checkOutput("str_mem_w_en", {31'b0, ex_mem_w_en}, 32'h1);
        checkOutput("str_wb_en", {31'b0, ex_wb_en}, 32'h0);
        checkOutput("str_cmd", {28'b0, ex_cmd}, 32'h2);
        checkOutput("str_imm24", {8'b0, ex_signed_imm_24}, 32'h801004);

        // LDR R1,[R0,#4]
        applyStimulus(1'b1, 32'hE5901004, 10'h028, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        #1;
        checkOutput("ldr_src2", {28'b0, src2}, 32'h4);
        stepCycle();
        checkOutput("ldr_mem_r_en", {31'b0, ex_mem_r_en}, 32'h1);
        checkOutput("ldr_wb_en", {31'b0, ex_wb_en}, 32'h1);
        checkOutput("ldr_mem_w_en", {31'b0, ex_mem_w_en}, 32'h0);

        // Branch
        applyStimulus(1'b1, 32'hEA000010, 10'h02C, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("b_b", {31'b0, ex_b}, 32'h1);
        checkOutput("b_cmd", {28'b0, ex_cmd}, 32'h0);
        checkOutput("b_wb_en", {31'b0, ex_wb_en}, 32'h0);
        checkOutput("b_imm24", {8'b0, ex_signed_imm_24}, 32'h000010);

        // Stall: control zero, data loads
        applyStimulus(1'b1, 32'hE0831003, 10'h123, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("stall_cmd", {28'b0, ex_cmd}, 32'h0);
        checkOutput("stall_wb_en", {31'b0, ex_wb_en}, 32'h0);
        checkOutput("stall_pc", {22'b0, ex_pc}, 32'h123);
        checkOutput("stall_val_rn", ex_val_rn, 32'hAA);

        // Stall plus flush: flush wins; write-back still lands (R5=0x77)
        applyStimulus(1'b1, 32'hE0831003, 10'h130, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5, 32'h77);
        stepCycle();
        checkOutput("flush_pc", {22'b0, ex_pc}, 32'h0);
        checkOutput("flush_val_rn", ex_val_rn, 32'h0);
        checkOutput("flush_dest", {28'b0, ex_dest}, 32'h0);
        checkOutput("flush_cmd", {28'b0, ex_cmd}, 32'h0);

        // ADD R6,R5,R5 sees the write made during flush
        applyStimulus(1'b1, 32'hE0856005, 10'h134, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("flush_wb_kept", ex_val_rn, 32'h77);

        // Same-cycle write of R2=0x55 while reading R2
        applyStimulus(1'b1, 32'hE0824002, 10'h138, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2, 32'h55);
        stepCycle();
        checkOutput("bypass_val_rn", ex_val_rn, bypass_exp);
        checkOutput("bypass_val_rm", ex_val_rm, bypass_exp);
        applyStimulus(1'b1, 32'hE0824002, 10'h13C, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("after_bypass_rn", ex_val_rn, 32'h55);

        // Mid-operation reset clears ID/EX and the register file
        applyStimulus(1'b0, 32'hE0831003, 10'h140, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("midrst_cmd", {28'b0, ex_cmd}, 32'h0);
        checkOutput("midrst_val_rn", ex_val_rn, 32'h0);
        checkOutput("midrst_pc", {22'b0, ex_pc}, 32'h0);
        applyStimulus(1'b1, 32'hE0831003, 10'h144, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        stepCycle();
        checkOutput("midrst_r3_cleared", ex_val_rn, 32'h0);
        checkOutput("midrst_add_cmd", {28'b0, ex_cmd}, 32'h2);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
